// File: rtl/nubus_bus_timeout.sv
// NuBus bus-timeout monitor.
// Watches NuBus transactions. If no slave ACKs within TMO_CLKS clocks of
// START, the block drives a one-clock timeout ACK (TM = 2'b10 on the wire,
// i.e. tm1n=0, tm0n=1). It also records the address and TM code of the
// timed-out transaction and keeps a saturating timeout count.
// All state changes on the falling edge of nub_clkn, which is the NuBus
// sampling edge. The bus drivers are decoded from registered state only.
module nubus_bus_timeout #(
    parameter int TMO_W    = 8,
    parameter int TMO_CLKS = 255
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,
    input  logic        nub_startn,
    input  logic [31:0] nub_adn,
    inout  logic        nub_ackn,
    inout  logic        nub_tm1n,
    inout  logic        nub_tm0n,
    input  logic        tmo_en,
    input  logic        tmo_clr,
    output logic        busy,
    output logic        tmo_valid,
    output logic [31:0] tmo_addr,
    output logic [1:0]  tmo_tm,
    output logic [15:0] tmo_cnt,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Counter value on the last WAIT sample before DRIVE. TMO_CLKS is at
    // most 2^TMO_W-1, so the counter never has to hold more than 2^TMO_W-2
    // and cannot wrap.
    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_CLKS - 1);
    localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

    // The sampling edge is the rising edge of the true-polarity clock.
    logic nub_clk;
    assign nub_clk = ~nub_clkn;

    state_t           state_q,     state_d;
    logic [TMO_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      cur_addr_q,  cur_addr_d;
    logic [1:0]       cur_tm_q,    cur_tm_d;
    logic             busy_q,      busy_d;
    logic             tmo_valid_q, tmo_valid_d;
    logic [31:0]      tmo_addr_q,  tmo_addr_d;
    logic [1:0]       tmo_tm_q,    tmo_tm_d;
    logic [15:0]      tmo_cnt_q,   tmo_cnt_d;
    logic             proto_err_q, proto_err_d;

    // Active-high views of the sampled bus lines.
    logic       start_s;
    logic       ack_s;
    logic [1:0] tm_s;
    assign start_s = ~nub_startn;
    assign ack_s   = ~nub_ackn;
    assign tm_s    = {~nub_tm1n, ~nub_tm0n};

    // Next-state, counter, capture and status logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_addr_d  = cur_addr_q;
        cur_tm_d    = cur_tm_q;
        tmo_addr_d  = tmo_addr_q;
        tmo_tm_d    = tmo_tm_q;
        tmo_cnt_d   = tmo_cnt_q;
        proto_err_d = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                // START with ACK high opens a transaction; START with ACK
                // low is an attention cycle and is ignored.
                if (tmo_en && start_s && !ack_s) begin
                    state_d    = ST_WAIT;
                    cnt_d      = '0;
                    cur_addr_d = ~nub_adn;
                    cur_tm_d   = tm_s;
                end
            end
            ST_WAIT: begin
                if (!tmo_en) begin
                    state_d = ST_IDLE;
                end else if (ack_s && !start_s) begin
                    // Normal slave completion.
                    state_d = ST_IDLE;
                end else if (start_s && !ack_s) begin
                    // A new START while a transaction is open is a protocol
                    // error; monitor the new transaction from scratch.
                    proto_err_d = 1'b1;
                    cur_addr_d  = ~nub_adn;
                    cur_tm_d    = tm_s;
                    cnt_d       = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // No ACK (attention cycles included) for TMO_CLKS clocks.
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_RECOVER;
            end
            default: begin
                // RECOVER: bus released, START ignored for this clock.
                state_d = ST_IDLE;
            end
        endcase

        // Timeout status is captured as DRIVE is entered, so it is visible
        // during the DRIVE clock together with tmo_valid.
        if (state_d == ST_DRIVE) begin
            tmo_addr_d = cur_addr_q;
            tmo_tm_d   = cur_tm_q;
            if (tmo_cnt_q != 16'hFFFF) begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end

        // Clear wins over a coincident increment or error.
        if (tmo_clr) begin
            tmo_cnt_d   = '0;
            proto_err_d = 1'b0;
        end

        busy_d      = (state_d == ST_WAIT);
        tmo_valid_d = (state_d == ST_DRIVE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge nub_clk) begin
        if (!nub_resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cur_addr_q  <= '0;
            cur_tm_q    <= '0;
            busy_q      <= 1'b0;
            tmo_valid_q <= 1'b0;
            tmo_addr_q  <= '0;
            tmo_tm_q    <= '0;
            tmo_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_addr_q  <= cur_addr_d;
            cur_tm_q    <= cur_tm_d;
            busy_q      <= busy_d;
            tmo_valid_q <= tmo_valid_d;
            tmo_addr_q  <= tmo_addr_d;
            tmo_tm_q    <= tmo_tm_d;
            tmo_cnt_q   <= tmo_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Bus drivers are enabled from the registered state only.
    logic drv_en;
    assign drv_en = (state_q == ST_DRIVE);

    assign nub_ackn = drv_en ? 1'b0 : 1'bz;
    assign nub_tm1n = drv_en ? 1'b0 : 1'bz;
    assign nub_tm0n = drv_en ? 1'b1 : 1'bz;

    assign busy      = busy_q;
    assign tmo_valid = tmo_valid_q;
    assign tmo_addr  = tmo_addr_q;
    assign tmo_tm    = tmo_tm_q;
    assign tmo_cnt   = tmo_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_nubus_bus_timeout.sv
// Bench for nubus_bus_timeout. The DUT samples on the falling edge of
// nub_clkn; the bench drives and observes on the rising edge of nub_clkn.
// The open-collector NuBus lines are modelled with pullups.
module tb_nubus_bus_timeout;

  localparam int TMO_CLKS = 255;

  // clock / reset
  logic nub_clkn = 1'b1;
  always #5 nub_clkn = ~nub_clkn;

  logic        nub_resetn;
  logic        nub_startn;
  logic [31:0] nub_adn;
  logic        tmo_en;
  logic        tmo_clr;
  wire         nub_ackn;
  wire         nub_tm1n;
  wire         nub_tm0n;
  logic        busy;
  logic        tmo_valid;
  logic [31:0] tmo_addr;
  logic [1:0]  tmo_tm;
  logic [15:0] tmo_cnt;
  logic        proto_err;

  // bench-side bus drivers (slave ACK and master TM)
  logic       slv_ack;
  logic       tm_oe;
  logic [1:0] tm_drv;

  pullup (nub_ackn);
  pullup (nub_tm1n);
  pullup (nub_tm0n);
  assign nub_ackn = slv_ack ? 1'b0 : 1'bz;
  assign nub_tm1n = tm_oe ? ~tm_drv[1] : 1'bz;
  assign nub_tm0n = tm_oe ? ~tm_drv[0] : 1'bz;

  nubus_bus_timeout #(.TMO_W(8), .TMO_CLKS(TMO_CLKS)) u_dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .nub_startn (nub_startn),
    .nub_adn    (nub_adn),
    .nub_ackn   (nub_ackn),
    .nub_tm1n   (nub_tm1n),
    .nub_tm0n   (nub_tm0n),
    .tmo_en     (tmo_en),
    .tmo_clr    (tmo_clr),
    .busy       (busy),
    .tmo_valid  (tmo_valid),
    .tmo_addr   (tmo_addr),
    .tmo_tm     (tmo_tm),
    .tmo_cnt    (tmo_cnt),
    .proto_err  (proto_err)
  );

  // sampling-edge counter
  int cyc = 0;
  always @(negedge nub_clkn) cyc <= cyc + 1;

  // scoreboard: {due cycle, tm, addr} of each expected timeout
  logic [65:0] exp_q[$];
  logic [15:0] exp_cnt;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge nub_clkn);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic start_txn(input logic [31:0] addr, input logic [1:0] tm, input bit push);
    nub_startn = 1'b0;
    nub_adn    = ~addr;
    tm_oe      = 1'b1;
    tm_drv     = tm;
    if (push) exp_q.push_back({32'(cyc + 1 + TMO_CLKS), tm, addr});
    step();
    nub_startn = 1'b1;
    tm_oe      = 1'b0;
    nub_adn    = $urandom;
  endtask

  // Waits for the timeout DRIVE clock and checks it against the scoreboard.
  task automatic wait_drive(input string tag);
    logic [65:0] e;
    int n = 0;
    while (tmo_valid !== 1'b1 && n < TMO_CLKS + 20) begin
      step();
      n++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    check({tag, "_valid"}, 32'(tmo_valid), 32'd1);
    check({tag, "_latency"}, 32'(cyc), e[65:34]);
    check({tag, "_addr"}, tmo_addr, e[31:0]);
    check({tag, "_tm"}, 32'(tmo_tm), 32'(e[33:32]));
    check({tag, "_ackn"}, 32'(nub_ackn), 32'd0);
    check({tag, "_tm1n"}, 32'(nub_tm1n), 32'd0);
    check({tag, "_tm0n"}, 32'(nub_tm0n), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cnt"}, 32'(tmo_cnt), 32'(exp_cnt));
  endtask

  // Steps through RECOVER back to IDLE, optionally offering a START in RECOVER.
  task automatic finish_drive(input string tag, input bit start_in_recover);
    step();
    check({tag, "_rec_valid"}, 32'(tmo_valid), 32'd0);
    check({tag, "_rec_ackn"}, 32'(nub_ackn), 32'd1);
    check({tag, "_rec_tm1n"}, 32'(nub_tm1n), 32'd1);
    if (start_in_recover) begin
      nub_startn = 1'b0;
      nub_adn    = ~32'hDEAD0000;
      tm_oe      = 1'b1;
      tm_drv     = 2'b11;
    end
    step();
    nub_startn = 1'b1;
    tm_oe      = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  // Watches n clocks for any unexpected timeout or ACK drive.
  task automatic watch_quiet(input string tag, input int n);
    int seen_valid = 0;
    int seen_ack = 0;
    repeat (n) begin
      step();
      if (tmo_valid === 1'b1) seen_valid++;
      if (nub_ackn !== 1'b1) seen_ack++;
    end
    check({tag, "_no_valid"}, 32'(seen_valid), 32'd0);
    check({tag, "_no_ack"}, 32'(seen_ack), 32'd0);
    check({tag, "_cnt"}, 32'(tmo_cnt), 32'(exp_cnt));
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nub_resetn = 1'b0;
    nub_startn = 1'b1;
    nub_adn    = '1;
    tmo_en     = 1'b1;
    tmo_clr    = 1'b0;
    slv_ack    = 1'b0;
    tm_oe      = 1'b0;
    tm_drv     = 2'b00;
    exp_cnt    = '0;

    // reset state
    steps(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(tmo_valid), 32'd0);
    check("rst_addr", tmo_addr, 32'd0);
    check("rst_tm", 32'(tmo_tm), 32'd0);
    check("rst_cnt", 32'(tmo_cnt), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    check("rst_ackn", 32'(nub_ackn), 32'd1);
    nub_resetn = 1'b1;
    step();

    // basic timeout; START offered during RECOVER must be ignored
    start_txn(32'hF3001000, 2'b01, 1'b1);
    check("basic_busy", 32'(busy), 32'd1);
    wait_drive("basic");
    finish_drive("basic", 1'b1);

    // slave ACK 10 clocks after START
    start_txn(32'h12345678, 2'b10, 1'b0);
    steps(9);
    slv_ack = 1'b1;
    step();
    slv_ack = 1'b0;
    check("slvack_busy", 32'(busy), 32'd0);
    watch_quiet("slvack", TMO_CLKS + 40);

    // attention cycle in IDLE is ignored
    nub_startn = 1'b0;
    slv_ack    = 1'b1;
    step();
    nub_startn = 1'b1;
    slv_ack    = 1'b0;
    check("idle_attn_busy", 32'(busy), 32'd0);

    // attention cycle at WAIT clock 5 does not end the transaction
    start_txn(32'hA0000000, 2'b11, 1'b1);
    steps(3);
    nub_startn = 1'b0;
    slv_ack    = 1'b1;
    step();
    nub_startn = 1'b1;
    slv_ack    = 1'b0;
    check("attn_busy", 32'(busy), 32'd1);
    check("attn_perr", 32'(proto_err), 32'd0);
    wait_drive("attn");
    finish_drive("attn", 1'b0);

    // second START at WAIT clock 100
    start_txn(32'h80000000, 2'b00, 1'b1);
    steps(98);
    exp_q.delete();
    start_txn(32'h90000004, 2'b10, 1'b1);
    check("perr_set", 32'(proto_err), 32'd1);
    check("perr_busy", 32'(busy), 32'd1);
    wait_drive("perr");
    finish_drive("perr", 1'b0);
    check("perr_sticky", 32'(proto_err), 32'd1);
    tmo_clr = 1'b1;
    step();
    tmo_clr = 1'b0;
    exp_cnt = '0;
    check("clr_cnt", 32'(tmo_cnt), 32'd0);
    check("clr_perr", 32'(proto_err), 32'd0);

    // monitor disabled: START ignored, and disabling in WAIT aborts
    tmo_en = 1'b0;
    start_txn(32'h11110000, 2'b01, 1'b0);
    check("dis_idle_busy", 32'(busy), 32'd0);
    tmo_en = 1'b1;
    start_txn(32'h22220000, 2'b01, 1'b0);
    steps(20);
    tmo_en = 1'b0;
    step();
    check("dis_wait_busy", 32'(busy), 32'd0);
    watch_quiet("dis", TMO_CLKS + 20);
    tmo_en = 1'b1;

    // reset asserted in DRIVE
    start_txn(32'h30000000, 2'b00, 1'b1);
    steps(5);
    exp_q.delete();
    start_txn(32'h40000008, 2'b11, 1'b1);
    wait_drive("rstdrv");
    nub_resetn = 1'b0;
    step();
    exp_cnt = '0;
    check("rstdrv_ackn", 32'(nub_ackn), 32'd1);
    check("rstdrv_tm1n", 32'(nub_tm1n), 32'd1);
    check("rstdrv_valid", 32'(tmo_valid), 32'd0);
    check("rstdrv_addr", tmo_addr, 32'd0);
    check("rstdrv_tm", 32'(tmo_tm), 32'd0);
    check("rstdrv_cnt", 32'(tmo_cnt), 32'd0);
    check("rstdrv_perr", 32'(proto_err), 32'd0);
    check("rstdrv_busy", 32'(busy), 32'd0);
    nub_resetn = 1'b1;
    step();
    start_txn(32'h50000010, 2'b01, 1'b1);
    wait_drive("postrst");
    finish_drive("postrst", 1'b0);

    // saturation: the count is placed one below the limit instead of
    // replaying 65534 timeouts
    force u_dut.tmo_cnt_d = 16'hFFFE;
    step();
    release u_dut.tmo_cnt_d;
    step();
    exp_cnt = 16'hFFFE;
    check("preload_cnt", 32'(tmo_cnt), 32'h0000FFFE);
    start_txn(32'h60000000, 2'b10, 1'b1);
    wait_drive("sat1");
    finish_drive("sat1", 1'b0);
    start_txn(32'h60000004, 2'b01, 1'b1);
    wait_drive("sat2");
    finish_drive("sat2", 1'b0);
    start_txn(32'h60000008, 2'b11, 1'b1);
    wait_drive("sat3");
    tmo_clr = 1'b1;
    finish_drive("satclr", 1'b0);
    tmo_clr = 1'b0;
    check("satclr_cnt", 32'(tmo_cnt), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nubus_bus_timeout.md
NUBUS_BUS_TIMEOUT -- requirements
Module: nubus_bus_timeout

Interface
REQ-001 Parameter TMO_W, default 8: width of the no-ACK cycle counter.
REQ-002 Parameter TMO_CLKS, default 255: number of WAIT clocks without ACK before a timeout ACK is driven; legal range 2..2^TMO_W-1.
REQ-003 nub_clkn  in  1  NuBus clock; all state updates on the falling edge of nub_clkn, i.e. the rising edge of nub_clk = ~nub_clkn, which is the sampling edge.
REQ-004 nub_resetn  in  1  reset, synchronous, active-low.
REQ-005 nub_startn  in  1  NuBus START, active-low.
REQ-006 nub_adn  in  32  NuBus address/data, active-low; sampled only, never driven.
REQ-007 nub_ackn  inout  1  NuBus ACK, active-low; driven only in DRIVE, otherwise Z.
REQ-008 nub_tm1n  inout  1  NuBus TM1, active-low; driven only in DRIVE, otherwise Z.
REQ-009 nub_tm0n  inout  1  NuBus TM0, active-low; driven only in DRIVE, otherwise Z.
REQ-010 tmo_en  in  1  1 = monitor enabled.
REQ-011 tmo_clr  in  1  1 = clear tmo_cnt and proto_err.
REQ-012 busy  out  1  1 while in WAIT.
REQ-013 tmo_valid  out  1  one-clock pulse when a timeout ACK is driven.
REQ-014 tmo_addr  out  32  address, active-high, of the last timed-out transaction.
REQ-015 tmo_tm  out  2  {TM1,TM0}, active-high, captured in the address cycle of the last timed-out transaction.
REQ-016 tmo_cnt  out  16  saturating count of timeouts.
REQ-017 proto_err  out  1  sticky flag for a START received while in WAIT.

Function
REQ-018 The block SHALL implement the states IDLE, WAIT, DRIVE and RECOVER.
REQ-019 In IDLE, a sample with tmo_en=1, nub_startn=0 and nub_ackn=1 SHALL do all of the following: go to WAIT, clear the counter to 0, and latch cur_addr=~nub_adn and cur_tm={~nub_tm1n,~nub_tm0n}.
REQ-020 In IDLE, a sample with nub_startn=0 and nub_ackn=0 is an attention cycle and SHALL be ignored.
REQ-021 In WAIT, a sample with nub_ackn=0 and nub_startn=1 is a normal completion and SHALL return the block to IDLE with no status change.
REQ-022 In WAIT, a sample with nub_ackn=0 and nub_startn=0 is an attention cycle, SHALL NOT terminate the transaction, and the counter SHALL still increment.
REQ-023 In WAIT, a sample with nub_startn=0 and nub_ackn=1 SHALL set proto_err, re-latch cur_addr and cur_tm, reset the counter to 0, and remain in WAIT.
REQ-024 In WAIT, a sample with no ACK SHALL increment the counter; when the counter equals TMO_CLKS-1 on that sample, the next state SHALL be DRIVE.
REQ-025 Timeout latency SHALL be exactly TMO_CLKS clocks from the START sample to the first DRIVE clock.
REQ-026 In WAIT, tmo_en=0 SHALL return the block to IDLE on the next clock without driving ACK.
REQ-027 DRIVE SHALL last exactly one clock, driving nub_ackn=0, nub_tm1n=0 and nub_tm0n=1 (timeout status code).
REQ-028 In DRIVE, tmo_valid SHALL be 1, tmo_addr SHALL take cur_addr, tmo_tm SHALL take cur_tm, and tmo_cnt SHALL increment, saturating at 16'hFFFF.
REQ-029 DRIVE SHALL go unconditionally to RECOVER.
REQ-030 RECOVER SHALL last one clock with all NuBus lines at Z, ignore START, and then go to IDLE.
REQ-031 The counter SHALL be TMO_W bits wide and SHALL never wrap, because it is reset on entry to WAIT and compared before overflow.
REQ-032 tmo_clr=1 SHALL zero tmo_cnt and proto_err on the next clock; if tmo_clr coincides with DRIVE, the clear SHALL win and tmo_cnt SHALL become 0.
REQ-033 The bus-enable signals SHALL be decoded from registered state only, so no combinational path exists from inputs to the enables.

Reset
REQ-034 While nub_resetn=0 at a sampling edge, the next state SHALL be IDLE and the counter 0.
REQ-035 On that same reset, busy=0, tmo_valid=0, tmo_addr=0, tmo_tm=0, tmo_cnt=0 and proto_err=0.
REQ-036 nub_ackn, nub_tm1n and nub_tm0n SHALL be Z during reset, including a reset asserted in DRIVE; the release SHALL take effect on the next sampling edge.
REQ-037 Reset SHALL have no asynchronous effect; outputs SHALL hold their values until the first sampling edge with nub_resetn=0.

Verification
REQ-038 Start with nub_adn=~32'hF3001000 and tm=01; no ACK; TMO_CLKS=255 -> ACK is low with tm1n=0, tm0n=1 exactly 255 clocks later for 1 clock; tmo_addr=32'hF3001000; tmo_tm=2'b01; tmo_cnt=1.
REQ-039 A slave ACKs (startn=1) 10 clocks after START -> returns to IDLE; the block never drives; tmo_valid is never 1; tmo_cnt is unchanged.
REQ-040 Attention cycle (startn=0, ackn=0) at WAIT clock 5, then no ACK -> timeout still occurs at clock 255.
REQ-041 Second START at WAIT clock 100 with address 32'h90000004 -> proto_err=1; timeout occurs 255 clocks after the second START with tmo_addr=32'h90000004.
REQ-042 nub_resetn=0 during DRIVE -> ACK and TM lines are Z from the next edge; all outputs return to 0; a following START is monitored normally.
REQ-043 tmo_cnt preloaded to 16'hFFFF via repeated timeouts -> stays at 16'hFFFF after a further timeout; tmo_clr pulsed on that DRIVE clock -> tmo_cnt=0.
